// File: rtl/dds_pkg.sv
// Shared types for the DDS parameter receiver: widths, FSM state encodings and
// the parameter-set record held in the shadow and active registers.
package dds_pkg;

  localparam int FW = 48;
  localparam int RW = 32;

  typedef enum logic [1:0] {
    H_WAIT,
    H_CAP,
    H_ACK
  } h_state_t;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } s_state_t;

  typedef struct packed {
    logic [FW-1:0] freq;
    logic [FW-1:0] delta_freq;
    logic [RW-1:0] delta_rate;
  } dds_param_t;

endpackage

// File: rtl/dds_param_rx_sync_bit.sv
// Single-bit multi-flop synchroniser (STAGES >= 2) with synchronous active-low
// reset, used to bring asynchronous levels into the CLK domain.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic din,
  output logic dout
);

  logic [STAGES-1:0] chain;

  // NOTE: non-blocking assignment so each stage takes the previous stage's old value.
  always_ff @(posedge CLK) begin
    if (!RESET_N) chain <= '0;
    else          chain <= {chain[STAGES-2:0], din};
  end

  assign dout = chain[STAGES-1];

endmodule

// File: rtl/dds_param_rx.sv
// DDS-domain receiver for the 4-phase REQ/ACK parameter transfer plus the
// linear chirp sweep. Optional phase accumulator enabled by `define DDS_PHASE_ACC_EN.
module dds_param_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int FW          = dds_pkg::FW,
  parameter int RW          = dds_pkg::RW
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          REQ,
  output logic          ACK,
  input  logic [FW-1:0] DDS_freq,
  input  logic [FW-1:0] DDS_delta_freq,
  input  logic [RW-1:0] DDS_delta_rate,
  input  logic          DDS_start,
  output logic [FW-1:0] FREQ_OUT,
  output logic          RUN,
  output logic          PARAM_VALID,
  output logic [FW-1:0] PHASE_OUT
);

  import dds_pkg::*;

  logic       req_s;
  logic       start_s;
  logic       start_d;
  logic       start_rise;
  logic       step;
  logic       ack_q;
  logic       valid_q;
  h_state_t   h_state;
  h_state_t   h_next;
  s_state_t   s_state;
  s_state_t   s_next;
  dds_param_t shadow;
  dds_param_t active;
  logic [RW-1:0] rate_cnt;

  sync_bit #(.STAGES(SYNC_STAGES)) u_req_sync (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .din     (REQ),
    .dout    (req_s)
  );

  sync_bit #(.STAGES(SYNC_STAGES)) u_start_sync (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .din     (DDS_start),
    .dout    (start_s)
  );

  // Handshake: H_CAP is entered once per synchronised REQ high period and
  // always proceeds to H_ACK, so a short REQ still yields one capture and ACK pulse.
  // NOTE: next state defaults to the current state first, so no path infers a latch.
  always_comb begin
    h_next = h_state;
    case (h_state)
      H_WAIT:  if (req_s) h_next = H_CAP;
      H_CAP:   h_next = H_ACK;
      H_ACK:   if (!req_s) h_next = H_WAIT;
      default: h_next = H_WAIT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      h_state <= H_WAIT;
      ack_q   <= 1'b0;
      valid_q <= 1'b0;
      shadow  <= '0;
    end else begin
      h_state <= h_next;
      ack_q   <= (h_next == H_ACK);
      if (h_state == H_CAP) begin
        shadow  <= '{freq: DDS_freq, delta_freq: DDS_delta_freq, delta_rate: DDS_delta_rate};
        valid_q <= 1'b1;
      end
    end
  end

  // Sweep: a run starts only on a rising start_s edge and loads the shadow set
  // as it was before this edge, so a simultaneous capture is not bypassed.
  always_comb begin
    start_rise = start_s & ~start_d;
    s_next     = s_state;
    step       = 1'b0;
    case (s_state)
      S_IDLE: if (start_rise) s_next = S_RUN;
      S_RUN: begin
        if (!start_s) s_next = S_IDLE;
        else          step   = (rate_cnt == active.delta_rate);
      end
      default: s_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      s_state  <= S_IDLE;
      start_d  <= 1'b0;
      active   <= '0;
      rate_cnt <= '0;
    end else begin
      s_state <= s_next;
      start_d <= start_s;
      if (s_state == S_IDLE && s_next == S_RUN) begin
        active   <= shadow;
        rate_cnt <= '0;
      end else if (s_state == S_RUN && s_next == S_RUN) begin
        if (step) begin
          active.freq <= active.freq + active.delta_freq;
          rate_cnt    <= '0;
        end else begin
          rate_cnt <= rate_cnt + RW'(1);
        end
      end
    end
  end

  assign ACK         = ack_q;
  assign PARAM_VALID = valid_q;
  assign RUN         = (s_state == S_RUN);
  assign FREQ_OUT    = active.freq;

`ifdef DDS_PHASE_ACC_EN
  logic [FW-1:0] phase_q;

  always_ff @(posedge CLK) begin
    if (!RESET_N)                                  phase_q <= '0;
    else if (s_state == S_IDLE && s_next == S_RUN) phase_q <= '0;
    else if (s_state == S_RUN)                     phase_q <= phase_q + active.freq;
  end

  assign PHASE_OUT = phase_q;
`else
  assign PHASE_OUT = '0;
`endif

endmodule

// File: tb/tb_dds_param_rx.sv
// Self-checking bench for dds_param_rx: handshake timing, sweep sequences,
// wrap, update while running, reset mid-transfer and the phase accumulator.
module tb_dds_param_rx;

  localparam int SS = 2;
  localparam int FW = 48;
  localparam int RW = 32;

  logic          CLK = 1'b0;
  logic          RESET_N;
  logic          REQ;
  logic          ACK;
  logic [FW-1:0] DDS_freq;
  logic [FW-1:0] DDS_delta_freq;
  logic [RW-1:0] DDS_delta_rate;
  logic          DDS_start;
  logic [FW-1:0] FREQ_OUT;
  logic          RUN;
  logic          PARAM_VALID;
  logic [FW-1:0] PHASE_OUT;

  dds_param_rx #(.SYNC_STAGES(SS), .FW(FW), .RW(RW)) dut (
    .CLK            (CLK),
    .RESET_N        (RESET_N),
    .REQ            (REQ),
    .ACK            (ACK),
    .DDS_freq       (DDS_freq),
    .DDS_delta_freq (DDS_delta_freq),
    .DDS_delta_rate (DDS_delta_rate),
    .DDS_start      (DDS_start),
    .FREQ_OUT       (FREQ_OUT),
    .RUN            (RUN),
    .PARAM_VALID    (PARAM_VALID),
    .PHASE_OUT      (PHASE_OUT)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  logic [FW-1:0] exp_q[$];
  logic [FW-1:0] m_f;
  logic [FW-1:0] m_df;
  logic [RW-1:0] m_r;
  int            m_k;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [FW-1:0] model_freq(input int k);
    int steps;
    steps = k / (int'(m_r) + 1);
    return m_f + m_df * FW'(steps);
  endfunction

  task automatic do_transfer(input logic [FW-1:0] f, input logic [FW-1:0] df,
                             input logic [RW-1:0] r, input string name);
    int n;
    DDS_freq       = f;
    DDS_delta_freq = df;
    DDS_delta_rate = r;
    REQ            = 1'b1;
    n = 0;
    while (ACK !== 1'b1 && n < 20) begin tick(); n++; end
    checks++;
    if (ACK !== 1'b1) begin
      errors++;
      $display("FAIL %s ack_rise: ACK=%b, required 1 within 20 cycles", name, ACK);
    end
    REQ = 1'b0;
    n = 0;
    while (ACK !== 1'b0 && n < 20) begin tick(); n++; end
    checks++;
    if (ACK !== 1'b0) begin
      errors++;
      $display("FAIL %s ack_fall: ACK=%b, required 0 within 20 cycles", name, ACK);
    end
  endtask

  task automatic start_run(input logic [FW-1:0] f, input logic [FW-1:0] df,
                           input logic [RW-1:0] r, input string name);
    int n;
    m_f = f; m_df = df; m_r = r; m_k = 0;
    DDS_start = 1'b1;
    n = 0;
    while (RUN !== 1'b1 && n < 20) begin tick(); n++; end
    checks++;
    if (RUN !== 1'b1) begin
      errors++;
      $display("FAIL %s run_rise: RUN=%b, required 1 within 20 cycles", name, RUN);
    end
  endtask

  // Current sample point always corresponds to sweep index m_k.
  task automatic check_run(input int n, input string name);
    logic [FW-1:0] e;
    for (int i = 0; i < n; i++) exp_q.push_back(model_freq(m_k + i));
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (FREQ_OUT !== e || RUN !== 1'b1) begin
        errors++;
        $display("FAIL %s freq[%0d]: FREQ_OUT=%h RUN=%b, required %h RUN=1",
                 name, m_k + i, FREQ_OUT, RUN, e);
      end
      tick();
    end
    m_k += n;
  endtask

  task automatic stop_run(input string name);
    int n;
    logic [FW-1:0] held;
    DDS_start = 1'b0;
    n = 0;
    while (RUN === 1'b1 && n < 20) begin
      checks++;
      if (FREQ_OUT !== model_freq(m_k)) begin
        errors++;
        $display("FAIL %s drain[%0d]: FREQ_OUT=%h, required %h", name, m_k, FREQ_OUT, model_freq(m_k));
      end
      tick(); m_k++; n++;
    end
    checks++;
    if (n != SS + 1) begin
      errors++;
      $display("FAIL %s stop_latency: RUN stayed %0d samples, required %0d", name, n, SS + 1);
    end
    held = model_freq(m_k - 1);
    tick(); tick(); tick();
    checks++;
    if (RUN !== 1'b0 || FREQ_OUT !== held) begin
      errors++;
      $display("FAIL %s hold: RUN=%b FREQ_OUT=%h, required RUN=0 FREQ_OUT=%h", name, RUN, FREQ_OUT, held);
    end
  endtask

  task automatic test_reset();
    RESET_N = 1'b0; REQ = 1'b0; DDS_start = 1'b0;
    DDS_freq = '0; DDS_delta_freq = '0; DDS_delta_rate = '0;
    tick(); tick(); tick();
    checks++;
    if (ACK !== 1'b0 || RUN !== 1'b0 || PARAM_VALID !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: ACK=%b RUN=%b PARAM_VALID=%b, required 0 0 0", ACK, RUN, PARAM_VALID);
    end
    checks++;
    if (FREQ_OUT !== '0 || PHASE_OUT !== '0) begin
      errors++;
      $display("FAIL reset_words: FREQ_OUT=%h PHASE_OUT=%h, required 0 0", FREQ_OUT, PHASE_OUT);
    end
    RESET_N = 1'b1;
    tick();
  endtask

  task automatic test_no_params();
    start_run('0, '0, '0, "noparam");
    check_run(6, "noparam");
    checks++;
    if (PARAM_VALID !== 1'b0) begin
      errors++;
      $display("FAIL noparam valid: PARAM_VALID=%b, required 0", PARAM_VALID);
    end
    stop_run("noparam");
  endtask

  task automatic test_handshake();
    logic exp_ack;
    DDS_freq = 48'h1000; DDS_delta_freq = 48'h10; DDS_delta_rate = 32'd3;
    REQ = 1'b1;
    for (int e = 1; e <= SS + 2; e++) begin
      tick();
      exp_ack = (e == SS + 2);
      checks++;
      if (ACK !== exp_ack) begin
        errors++;
        $display("FAIL hs ack_rise edge %0d: ACK=%b, required %b", e, ACK, exp_ack);
      end
    end
    checks++;
    if (PARAM_VALID !== 1'b1) begin
      errors++;
      $display("FAIL hs valid: PARAM_VALID=%b, required 1", PARAM_VALID);
    end
    REQ = 1'b0;
    for (int e = 1; e <= SS + 1; e++) begin
      tick();
      exp_ack = (e < SS + 1);
      checks++;
      if (ACK !== exp_ack) begin
        errors++;
        $display("FAIL hs ack_fall edge %0d: ACK=%b, required %b", e, ACK, exp_ack);
      end
    end
    tick();
  endtask

  task automatic test_sweep();
    start_run(48'h1000, 48'h10, 32'd3, "sweep");
    check_run(16, "sweep");
    stop_run("sweep");
  endtask

  task automatic test_wrap();
    do_transfer(48'hFFFF_FFFF_FFF0, 48'h20, 32'd0, "wrap");
    start_run(48'hFFFF_FFFF_FFF0, 48'h20, 32'd0, "wrap");
    check_run(6, "wrap");
    stop_run("wrap");
  endtask

  task automatic test_short_req();
    int highs;
    DDS_freq = 48'h500; DDS_delta_freq = 48'h5; DDS_delta_rate = 32'd1;
    REQ = 1'b1;
    tick();
    REQ = 1'b0;
    highs = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (ACK === 1'b1) highs++; end
    checks++;
    if (highs != 1) begin
      errors++;
      $display("FAIL short_req ack_pulse: ACK high %0d cycles, required 1", highs);
    end
    start_run(48'h500, 48'h5, 32'd1, "short_req");
    check_run(8, "short_req");
    stop_run("short_req");
  endtask

  task automatic test_update_while_running();
    do_transfer(48'h1000, 48'h10, 32'd3, "upd_load");
    start_run(48'h1000, 48'h10, 32'd3, "upd_run");
    check_run(4, "upd_run");
    fork
      do_transfer(48'h2000, 48'h1, 32'd1, "upd_xfer");
      check_run(20, "upd_run");
    join
    stop_run("upd_run");
    start_run(48'h2000, 48'h1, 32'd1, "upd_restart");
    check_run(8, "upd_restart");
    stop_run("upd_restart");
  endtask

  task automatic test_phase();
    logic [FW-1:0] e;
    do_transfer(48'h100, 48'h0, 32'd0, "phase");
    start_run(48'h100, 48'h0, 32'd0, "phase");
    for (int i = 0; i < 8; i++) begin
`ifdef DDS_PHASE_ACC_EN
      e = 48'h100 * FW'(i);
`else
      e = '0;
`endif
      checks++;
      if (PHASE_OUT !== e) begin
        errors++;
        $display("FAIL phase[%0d]: PHASE_OUT=%h, required %h", i, PHASE_OUT, e);
      end
      tick();
    end
    m_k += 8;
    stop_run("phase");
  endtask

  task automatic test_reset_mid_transfer();
    int n;
    DDS_freq = 48'h3000; DDS_delta_freq = 48'h3; DDS_delta_rate = 32'd2;
    REQ = 1'b1;
    n = 0;
    while (ACK !== 1'b1 && n < 20) begin tick(); n++; end
    checks++;
    if (ACK !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid ack: ACK=%b, required 1 within 20 cycles", ACK);
    end
    RESET_N = 1'b0;
    tick();
    checks++;
    if (ACK !== 1'b0 || PARAM_VALID !== 1'b0 || FREQ_OUT !== '0) begin
      errors++;
      $display("FAIL rst_mid clear: ACK=%b PARAM_VALID=%b FREQ_OUT=%h, required 0 0 0",
               ACK, PARAM_VALID, FREQ_OUT);
    end
    RESET_N = 1'b1;
    REQ = 1'b0;
    tick(); tick();
    do_transfer(48'h4000, 48'h2, 32'd0, "rst_mid_new");
    checks++;
    if (PARAM_VALID !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid valid: PARAM_VALID=%b, required 1", PARAM_VALID);
    end
    start_run(48'h4000, 48'h2, 32'd0, "rst_mid_run");
    check_run(4, "rst_mid_run");
    stop_run("rst_mid_run");
  endtask

  initial begin
    test_reset();
    test_no_params();
    test_handshake();
    test_sweep();
    test_wrap();
    test_short_req();
    test_update_while_running();
    test_phase();
    test_reset_mid_transfer();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
